tradeoff_search_ctrl: RTL and testbench
=======================================

TRADEOFF_SEARCH_CTRL -- requirements
Module: tradeoff_search_ctrl

Interface
REQ-001 SHALL have parameter W_BITS, default 20, width of search target W.
REQ-002 SHALL have parameter N_BITS, default 9, width of search result N.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, maximum RUN cycles before abort (timeout build only).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_w input W_BITS: job request handshake.
REQ-007 SHALL have port eng_w  output  W_BITS  target driven to downstream Tradeoff search engine W.
REQ-008 SHALL have port eng_rst_n  output  1  active-low restart to engine rst_n.
REQ-009 SHALL have ports eng_found input 1, eng_n input N_BITS: engine completion flag and result.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_w output W_BITS, out_n output N_BITS, out_timeout output 1: result handshake.
REQ-011 SHALL have port jobs_done  output  16  count of completed result handshakes.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-013 in_ready SHALL be 1 in IDLE, and in DONE only when out_ready=1; 0 otherwise.
REQ-014 On in_valid&in_ready SHALL latch in_w into eng_w and enter LOAD next cycle.
REQ-015 LOAD SHALL last exactly 1 cycle with eng_rst_n=0; eng_rst_n=1 in all other states.
REQ-016 eng_w SHALL remain stable from LOAD until the next accepted request.
REQ-017 RUN SHALL sample eng_found each cycle; eng_found=1 -> capture eng_n into out_n, eng_w into out_w, out_timeout=0, enter DONE.
REQ-018 Latency: accept at cycle 0, LOAD cycle 1, RUN from cycle 2; eng_found high at cycle k -> out_valid=1 at cycle k+1.
REQ-019 out_valid SHALL be 1 exactly in DONE; out_w/out_n/out_timeout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 and in_valid=0 -> IDLE; with out_ready=1 and in_valid=1 -> accept new job, go directly to LOAD (no bubble).
REQ-021 jobs_done SHALL increment by 1 on each out_valid&out_ready; wraps 0xFFFF -> 0x0000.
REQ-022 eng_found/eng_n SHALL be ignored in IDLE, LOAD, DONE.
REQ-023 in_w SHALL be ignored when in_ready=0.

Reset
REQ-024 rst=1 SHALL asynchronously force: state IDLE, in_ready=1 after release, out_valid=0, out_w=0, out_n=0, out_timeout=0, eng_w=0, eng_rst_n=0, jobs_done=0, timeout counter=0.
REQ-025 While rst=1, eng_rst_n SHALL be 0 (engine held in reset); first cycle after release eng_rst_n=1.
REQ-026 rst asserted mid-RUN or mid-DONE SHALL discard the in-flight job; no out_valid for it after release.

Configuration
REQ-027 Macro TRADEOFF_TIMEOUT_EN defined: counter counts RUN cycles; reaching TIMEOUT_CYC without eng_found -> out_n=all ones, out_timeout=1, enter DONE; eng_found on the same cycle as expiry wins (normal result).
REQ-028 Macro TRADEOFF_TIMEOUT_EN undefined: no counter, RUN waits indefinitely, out_timeout tied 0, TIMEOUT_CYC unused.

Verification
REQ-029 in_w=494446, engine model asserts eng_found with eng_n=255 after 300 RUN cycles, out_ready=1 -> out_valid one cycle later, out_w=494446, out_n=255, out_timeout=0, jobs_done=1.
REQ-030 Same job, out_ready=0 for 20 cycles -> out_valid held, out_n=255 stable, in_ready=0; out_ready=1 -> handshake, IDLE.
REQ-031 Back-to-back: in_valid=1 with in_w=494444 during DONE/out_ready=1 -> LOAD next cycle, eng_rst_n=0 one cycle, eng_w=494444.
REQ-032 TRADEOFF_TIMEOUT_EN, TIMEOUT_CYC=50, eng_found never asserted -> out_valid after 50 RUN cycles, out_n=511, out_timeout=1.
REQ-033 rst pulsed at RUN cycle 100 of job in_w=494447 -> out_valid=0, eng_rst_n=0 during rst, in_ready=1 after release, no result for 494447, jobs_done=0.

Source files
------------

// File: rtl/tradeoff_search_ctrl.sv
// Job controller for a Tradeoff search engine: accepts a target, restarts the engine,
// waits for its result and hands it downstream. Define TRADEOFF_TIMEOUT_EN to abort slow searches.
module tradeoff_search_ctrl #(
   parameter int W_BITS      = 20,
   parameter int N_BITS      = 9,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_BITS-1:0] in_w,
   output logic [W_BITS-1:0] eng_w,
   output logic              eng_rst_n,
   input  logic              eng_found,
   input  logic [N_BITS-1:0] eng_n,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W_BITS-1:0] out_w,
   output logic [N_BITS-1:0] out_n,
   output logic              out_timeout,
   output logic [15:0]       jobs_done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [W_BITS-1:0] eng_w_q, eng_w_d;
   logic [W_BITS-1:0] out_w_q, out_w_d;
   logic [N_BITS-1:0] out_n_q, out_n_d;
   logic [15:0]       jobs_done_q, jobs_done_d;

`ifdef TRADEOFF_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_timeout_q, out_timeout_d;
   logic             expired;

   // cnt_q holds the number of RUN cycles already spent, so the last allowed one is TIMEOUT_CYC-1
   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      eng_w_d     = eng_w_q;
      out_w_d     = out_w_q;
      out_n_d     = out_n_q;
      jobs_done_d = jobs_done_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
`ifdef TRADEOFF_TIMEOUT_EN
      cnt_d         = cnt_q;
      out_timeout_d = out_timeout_q;
`endif
      unique case (state_q)
         IDLE: in_ready = 1'b1;
         LOAD: begin
            state_d = RUN;
`ifdef TRADEOFF_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         RUN: begin
            if (eng_found) begin
               out_w_d = eng_w_q;
               out_n_d = eng_n;
               state_d = DONE;
`ifdef TRADEOFF_TIMEOUT_EN
               out_timeout_d = 1'b0;
            end else if (expired) begin
               out_w_d       = eng_w_q;
               out_n_d       = '1;
               out_timeout_d = 1'b1;
               state_d       = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               jobs_done_d = jobs_done_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Acceptance from DONE overrides the return to IDLE, giving back-to-back jobs without a bubble
      if (in_valid && in_ready) begin
         eng_w_d = in_w;
         state_d = LOAD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         eng_w_q     <= '0;
         out_w_q     <= '0;
         out_n_q     <= '0;
         jobs_done_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         eng_w_q     <= eng_w_d;
         out_w_q     <= out_w_d;
         out_n_q     <= out_n_d;
         jobs_done_q <= jobs_done_d;
      end
   end

`ifdef TRADEOFF_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q         <= '0;
         out_timeout_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         out_timeout_q <= out_timeout_d;
      end
   end

   assign out_timeout = out_timeout_q;
`else
   assign out_timeout = 1'b0;
`endif

   // The engine is held in reset while rst is high, not just from the next edge
   assign eng_rst_n = !rst && (state_q != LOAD);
   assign eng_w     = eng_w_q;
   assign out_w     = out_w_q;
   assign out_n     = out_n_q;
   assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_tradeoff_search_ctrl.sv
// Randomized scoreboard bench for tradeoff_search_ctrl with a behavioural search-engine model.
// Build with TRADEOFF_TIMEOUT_EN defined to also cover the abort path.
module tb_tradeoff_search_ctrl;
   localparam int W  = 20;
   localparam int N  = 9;
   localparam int TO = 50;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_w = '0;
   logic [W-1:0] eng_w;
   logic         eng_rst_n;
   logic         eng_found = 1'b0;
   logic [N-1:0] eng_n = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_w;
   logic [N-1:0] out_n;
   logic         out_timeout;
   logic [15:0]  jobs_done;

   tradeoff_search_ctrl #(.W_BITS(W), .N_BITS(N), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
      .eng_w(eng_w), .eng_rst_n(eng_rst_n),
      .eng_found(eng_found), .eng_n(eng_n),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_w(out_w), .out_n(out_n), .out_timeout(out_timeout),
      .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] w;
      logic [N-1:0] n;
      logic         to;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Expected result of a job, derived from the engine latency and the abort rule
   function automatic exp_t model(input logic [W-1:0] w, input int lat, input logic [N-1:0] n,
                                  input int acc_cyc);
      exp_t e;
      e.w   = w;
      e.n   = n;
      e.to  = 1'b0;
      e.due = acc_cyc + lat + 2;
`ifdef TRADEOFF_TIMEOUT_EN
      if (lat > TO) begin
         e.n   = '1;
         e.to  = 1'b1;
         e.due = acc_cyc + TO + 2;
      end
`endif
      return e;
   endfunction

   // Engine model: finishes after cur_lat cycles out of reset, then holds found high
   int           run_cyc = 0;
   int           cur_lat = 1000000;
   logic [N-1:0] cur_n   = '0;

   always @(negedge clk) begin
      if (!eng_rst_n) run_cyc = 0;
      else            run_cyc++;
      eng_found = eng_rst_n && (run_cyc >= cur_lat);
      eng_n     = eng_found ? cur_n : N'($urandom);
   end

   // Downstream readiness: 0 random, 1 always ready, 2 stalled
   int ready_mode = 1;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       out_ready = 1'b1;
         2:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(3) != 0);
      endcase
   end

   // Monitor
   logic [15:0] exp_done   = '0;
   bit          presenting = 1'b0;
   exp_t        head;

   always @(negedge clk) begin
      if (rst) begin
         check("out_valid_in_reset", out_valid, 0);
         check("eng_rst_n_in_reset", eng_rst_n, 0);
         exp_done   = '0;
         presenting = 1'b0;
      end else begin
         check("jobs_done", jobs_done, exp_done);
         if (out_valid) begin
            check("in_ready_in_done", in_ready, out_ready);
            check("result_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               head = sb[0];
               if (!presenting) begin
                  check("latency", cyc, head.due);
                  check("out_w", out_w, head.w);
                  check("out_n", out_n, head.n);
                  check("out_timeout", out_timeout, head.to);
                  presenting = 1'b1;
               end
               if (out_ready) begin
                  check("out_w_at_handshake", out_w, head.w);
                  check("out_n_at_handshake", out_n, head.n);
                  check("out_timeout_at_handshake", out_timeout, head.to);
                  void'(sb.pop_front());
                  presenting = 1'b0;
                  exp_done   = exp_done + 16'd1;
               end
            end
         end
      end
   end

   // Presents one job; starts and ends just after a rising edge
   task automatic issue(input logic [W-1:0] w, input int lat, input logic [N-1:0] n,
                        input bit expect_result);
      bit acc = 1'b0;
      int waited = 0;
      in_valid = 1'b1;
      in_w     = w;
      while (!acc && waited < 2000) begin
         @(negedge clk);
         if (in_ready) begin
            acc     = 1'b1;
            cur_lat = lat;
            cur_n   = n;
            if (expect_result) sb.push_back(model(w, lat, n, cyc));
         end
         @(posedge clk);
         #1;
         waited++;
      end
      in_valid = 1'b0;
      in_w     = W'($urandom);
      check("accepted_in_time", acc, 1);
      @(negedge clk);
      check("eng_rst_n_load", eng_rst_n, 0);
      check("eng_w_load", eng_w, w);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("eng_rst_n_run", eng_rst_n, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int waited = 0;
      while ((sb.size() != 0 || out_valid) && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset values
      @(negedge clk);
      check("rst_out_w", out_w, 0);
      check("rst_out_n", out_n, 0);
      check("rst_out_timeout", out_timeout, 0);
      check("rst_eng_w", eng_w, 0);
      check("rst_jobs_done", jobs_done, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      check("eng_rst_n_after_rst", eng_rst_n, 1);
      @(posedge clk);
      #1;

      // Long search, always ready
      issue(20'd494446, 300, 9'd255, 1'b1);
      drain();

      // Same job with a 20-cycle downstream stall
      @(negedge clk);
      ready_mode = 2;
      @(posedge clk);
      #1;
      issue(20'd494446, 300, 9'd255, 1'b1);
      begin
         int waited = 0;
         while (!out_valid && waited < 1000) begin
            @(negedge clk);
            waited++;
         end
         check("stall_result_seen", out_valid, 1);
      end
      repeat (20) @(negedge clk);
      check("out_n_held_stall", out_n, 255);
      check("in_ready_stall", in_ready, 0);
      ready_mode = 1;
      drain();

      // Back-to-back acceptance from DONE
      issue(20'd494440, 5, 9'd3, 1'b1);
      issue(20'd494444, 4, 9'd7, 1'b1);
      drain();

`ifdef TRADEOFF_TIMEOUT_EN
      issue(20'd1000, 1000000, 9'd5, 1'b1);
      issue(20'd1001, TO, 9'd6, 1'b1);
      issue(20'd1002, TO + 1, 9'd7, 1'b1);
      drain();
`endif

      // Random traffic with random downstream backpressure
      @(negedge clk);
      ready_mode = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
`ifdef TRADEOFF_TIMEOUT_EN
         issue(W'($urandom), $urandom_range(60, 1), N'($urandom), 1'b1);
`else
         issue(W'($urandom), $urandom_range(40, 1), N'($urandom), 1'b1);
`endif
         if ($urandom_range(3) == 0) repeat ($urandom_range(4)) @(posedge clk);
         #1;
      end
      @(negedge clk);
      ready_mode = 1;
      drain();

      // Reset mid-RUN discards the job
      issue(20'd494447, 200, 9'd9, 1'b0);
      repeat (98) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_mid_run_out_valid", out_valid, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_mid_rst", in_ready, 1);
      check("jobs_done_after_mid_rst", jobs_done, 0);
      check("eng_rst_n_after_mid_rst", eng_rst_n, 1);
      repeat (300) @(negedge clk);
      check("no_result_after_mid_rst", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
